// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: byte-addressed RAM with RV32I
// load/store sizing, valid/ready request side and a one-cycle response pulse.
module data_mem_responder #(
  parameter int    ADDR_WIDTH = 17,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_count;
  logic [31:0]             r_pendData;
  logic                    r_pendErr;
  logic [7:0]              r_mem [0:(2**ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [ADDR_WIDTH-3:0]   w_wordIdx;
  logic [1:0]              w_lane;
  logic                    w_accept;
  logic [31:0]             w_word;
  logic [31:0]             w_shifted;
  logic [31:0]             w_wdataShift;
  logic [31:0]             w_load;
  logic [31:0]             w_rdata;
  logic [3:0]              w_be;
  logic                    w_err;
  logic                    w_unused;

  assign w_addr       = req_addr_i[ADDR_WIDTH-1:0];
  assign w_wordIdx    = w_addr[ADDR_WIDTH-1:2];
  assign w_lane       = w_addr[1:0];
  assign w_accept     = req_valid_i & req_ready_o;
  assign w_word       = {r_mem[{w_wordIdx, 2'd3}], r_mem[{w_wordIdx, 2'd2}],
                         r_mem[{w_wordIdx, 2'd1}], r_mem[{w_wordIdx, 2'd0}]};
  assign w_shifted    = w_word >> {w_lane, 3'b000};
  assign w_wdataShift = req_wdata_i << {w_lane, 3'b000};
  assign w_unused     = ^{req_addr_i[31:ADDR_WIDTH], w_shifted[31:16]};

  assign req_ready_o  = (r_state == S_IDLE) || (r_state == S_RESP);
  assign busy_o       = (r_state == S_WAIT);

  // Size/alignment decode: byte enables for stores, extended data for loads.
  always_comb begin
    w_be   = 4'b0000;
    w_err  = 1'b0;
    w_load = 32'h0;
    if (req_write_i) begin
      case (req_funct3_i)
        3'd0: w_be = 4'b0001 << w_lane;
        3'd1: if (w_lane[0]) w_err = 1'b1; else w_be = 4'b0011 << w_lane;
        3'd2: if (w_lane != 2'd0) w_err = 1'b1; else w_be = 4'b1111;
        default: w_err = 1'b1;
      endcase
    end else begin
      case (req_funct3_i)
        3'd0: w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
        3'd4: w_load = {24'h0, w_shifted[7:0]};
        3'd1: if (w_lane[0]) w_err = 1'b1; else w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
        3'd5: if (w_lane[0]) w_err = 1'b1; else w_load = {16'h0, w_shifted[15:0]};
        3'd2: if (w_lane != 2'd0) w_err = 1'b1; else w_load = w_word;
        default: w_err = 1'b1;
      endcase
    end
    w_rdata = w_err ? 32'h0 : w_load;
  end

  // RAM is not reset; a write is blocked while reset is held.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[{w_wordIdx, 2'(k)}] <= w_wdataShift[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= 4'd0;
      r_pendData   <= 32'h0;
      r_pendErr    <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= 32'h0;
      resp_err_o   <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      if (w_accept) begin
        r_pendData <= w_rdata;
        r_pendErr  <= w_err;
      end
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            if (LATENCY == 1) begin
              r_state      <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_rdata_o <= w_rdata;
              resp_err_o   <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_count <= 4'(LATENCY - 2);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_count == 4'd0) begin
            r_state      <= S_RESP;
            resp_valid_o <= 1'b1;
            resp_rdata_o <= r_pendData;
            resp_err_o   <= r_pendErr;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, latency/back-to-back
// sequences, reset-abort sequences and randomized traffic against a byte-array model.
module tb_data_mem_responder;

  localparam logic [31:0] ADDR_MASK = 32'h0001_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [2:0]  reqFunct3 = 3'd0;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWdata = 32'h0;
  logic        reqReady, respValid, respErr, busy;
  logic [31:0] respRdata;

  logic        d1Valid = 1'b0, d1Ready, d1RespValid, d1Err, d1Busy;
  logic [31:0] d1Rdata;
  logic        d3Valid = 1'b0, d3Ready, d3RespValid, d3Err, d3Busy;
  logic [31:0] d3Rdata;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] modelMem [int];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_write_i(reqWrite), .req_funct3_i(reqFunct3), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .resp_valid_o(respValid), .resp_rdata_o(respRdata),
    .resp_err_o(respErr), .busy_o(busy));

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid_i(d1Valid), .req_ready_o(d1Ready),
    .req_write_i(reqWrite), .req_funct3_i(reqFunct3), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .resp_valid_o(d1RespValid), .resp_rdata_o(d1Rdata),
    .resp_err_o(d1Err), .busy_o(d1Busy));

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid_i(d3Valid), .req_ready_o(d3Ready),
    .req_write_i(reqWrite), .req_funct3_i(reqFunct3), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .resp_valid_o(d3RespValid), .resp_rdata_o(d3Rdata),
    .resp_err_o(d3Err), .busy_o(d3Busy));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One request: wait for ready, handshake, then count cycles up to the response pulse.
  task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat, output int busyN,
                               output logic [31:0] rd, output logic er);
    int guard;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqFunct3 = f3; reqAddr = addr; reqWdata = wdata;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0; busyN = 0; rd = 32'h0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) busyN++;
      if (respValid) begin
        lat = c; rd = respRdata; er = respErr;
        break;
      end
    end
  endtask

  // Reference: access size and extension chosen from funct3, bytes held in a sparse array.
  function automatic void modelAccess(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int size;
    logic signExt;
    logic [31:0] v;
    int key;
    size = 0; signExt = 1'b0; er = 1'b0; rd = 32'h0; v = 32'h0;
    if (wr) begin
      if (f3 <= 3'd2) size = 1 << f3;
    end else begin
      case (f3)
        3'd0: begin size = 1; signExt = 1'b1; end
        3'd1: begin size = 2; signExt = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    if (size == 0) er = 1'b1;
    else if ((addr % size) != 0) er = 1'b1;
    if (er) return;
    for (int i = 0; i < size; i++) begin
      key = int'((addr + 32'(i)) & ADDR_MASK);
      if (wr) modelMem[key] = wdata[8*i +: 8];
      else v |= 32'(modelMem[key]) << (8*i);
    end
    if (!wr) begin
      if (signExt && v[8*size-1]) v |= 32'hFFFF_FFFF << (8*size);
      rd = v;
    end
  endfunction

  function automatic void expectedPattern(input int lat, input int nReq,
                                          output logic [15:0] pulses, output logic [15:0] busyPat);
    pulses = 16'h0; busyPat = 16'h0;
    for (int j = 0; j < nReq; j++) begin
      pulses[j*lat + lat - 1] = 1'b1;
      for (int b = 0; b < lat - 1; b++) busyPat[j*lat + b] = 1'b1;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, busyN, acc1, acc3, bad1, bad3, pulses;
    logic [31:0] rd, expRd;
    logic er, expEr, wr;
    logic [2:0] f3;
    logic [31:0] addr, wdata;
    logic [15:0] pat1, bz1, pat3, bz3, expPat, expBz;

    vecs.push_back('{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, "SW 0x100"});
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, "LW 0x100"});
    vecs.push_back('{1'b0, 3'd0, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0, "LB 0x103"});
    vecs.push_back('{1'b0, 3'd4, 32'h103, 32'h0,        32'h000000DE, 1'b0, "LBU 0x103"});
    vecs.push_back('{1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, "LH 0x102"});
    vecs.push_back('{1'b0, 3'd5, 32'h100, 32'h0,        32'h0000BEEF, 1'b0, "LHU 0x100"});
    vecs.push_back('{1'b1, 3'd0, 32'h101, 32'hAAAAAA12, 32'h0,        1'b0, "SB 0x101"});
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEAD12EF, 1'b0, "LW after SB"});
    vecs.push_back('{1'b0, 3'd2, 32'h102, 32'h0,        32'h0,        1'b1, "LW misaligned"});
    vecs.push_back('{1'b1, 3'd1, 32'h101, 32'h00005555, 32'h0,        1'b1, "SH misaligned"});
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEAD12EF, 1'b0, "LW after bad SH"});
    vecs.push_back('{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b1, "load f3=3"});
    vecs.push_back('{1'b1, 3'd4, 32'h100, 32'h11111111, 32'h0,        1'b1, "store f3=4"});
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEAD12EF, 1'b0, "LW after bad store"});
    vecs.push_back('{1'b0, 3'd0, 32'h101, 32'h0,        32'h00000012, 1'b0, "LB 0x101"});
    vecs.push_back('{1'b0, 3'd5, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, "LHU 0x102"});
    vecs.push_back('{1'b1, 3'd1, 32'h102, 32'h1234CAFE, 32'h0,        1'b0, "SH 0x102"});
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        32'hCAFE12EF, 1'b0, "LW after SH"});
    vecs.push_back('{1'b0, 3'd0, 32'h100, 32'h0,        32'hFFFFFFEF, 1'b0, "LB 0x100"});
    vecs.push_back('{1'b0, 3'd2, 32'h20100, 32'h0,      32'hCAFE12EF, 1'b0, "LW wrapped addr"});
    vecs.push_back('{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        1'b1, "LH misaligned"});

    repeat (3) @(negedge clk);
    checkOutput("reset ready", 32'(reqReady), 32'd1);
    checkOutput("reset resp_valid", 32'(respValid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rdata", respRdata, 32'h0);
    checkOutput("reset err", 32'(respErr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after first reset", 32'(reqReady), 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, busyN, rd, er);
      checkOutput($sformatf("vec%0d %s latency", i, vecs[i].name), 32'(lat), 32'd2);
      checkOutput($sformatf("vec%0d %s busy cycles", i, vecs[i].name), 32'(busyN), 32'd1);
      checkOutput($sformatf("vec%0d %s rdata", i, vecs[i].name), rd, vecs[i].expData);
      checkOutput($sformatf("vec%0d %s err", i, vecs[i].name), 32'(er), 32'(vecs[i].expErr));
    end

    // Back-to-back: LATENCY=1 holds valid for 4 requests, LATENCY=3 for 2 requests.
    reqWrite = 1'b1; reqFunct3 = 3'd0; reqAddr = 32'h10; reqWdata = 32'h000000A5;
    acc1 = 0; acc3 = 0; bad1 = 0; bad3 = 0;
    pat1 = 16'h0; bz1 = 16'h0; pat3 = 16'h0; bz3 = 16'h0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      d1Valid = (k < 4);
      d3Valid = (k < 6);
      if (d1Valid && d1Ready) acc1++;
      if (d3Valid && d3Ready) acc3++;
      @(negedge clk);
      if (d1RespValid) begin
        pat1[k] = 1'b1;
        if (d1Err || d1Rdata != 32'h0) bad1++;
      end
      if (d3RespValid) begin
        pat3[k] = 1'b1;
        if (d3Err || d3Rdata != 32'h0) bad3++;
      end
      if (d1Busy) bz1[k] = 1'b1;
      if (d3Busy) bz3[k] = 1'b1;
    end
    d1Valid = 1'b0; d3Valid = 1'b0;
    expectedPattern(1, 4, expPat, expBz);
    checkOutput("lat1 accepts", 32'(acc1), 32'd4);
    checkOutput("lat1 pulse pattern", 32'(pat1), 32'(expPat));
    checkOutput("lat1 busy pattern", 32'(bz1), 32'(expBz));
    checkOutput("lat1 store responses", 32'(bad1), 32'd0);
    expectedPattern(3, 2, expPat, expBz);
    checkOutput("lat3 accepts", 32'(acc3), 32'd2);
    checkOutput("lat3 pulse pattern", 32'(pat3), 32'(expPat));
    checkOutput("lat3 busy pattern", 32'(bz3), 32'(expBz));
    checkOutput("lat3 store responses", 32'(bad3), 32'd0);

    // Reset one cycle after an LW is accepted: the response must never appear.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqFunct3 = 3'd2; reqAddr = 32'h100;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    checkOutput("busy before mid-op reset", 32'(busy), 32'd1);
    rst = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (respValid) pulses++;
    end
    checkOutput("rdata cleared by reset", respRdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset release", 32'(reqReady), 32'd1);
    repeat (3) begin
      if (respValid) pulses++;
      @(negedge clk);
    end
    checkOutput("pulses after aborted LW", 32'(pulses), 32'd0);

    // A store accepted just before reset stays in RAM.
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'd2; reqAddr = 32'h300; reqWdata = 32'h0BADF00D;
    @(posedge clk);
    #1 reqValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd2, 32'h300, 32'h0, lat, busyN, rd, er);
    checkOutput("store survives reset", rd, 32'h0BADF00D);
    checkOutput("store survives reset latency", 32'(lat), 32'd2);

    // Randomized traffic in a 64-byte window, preloaded so every load reads known bytes.
    for (int w = 0; w < 16; w++) begin
      addr = 32'h200 + 32'(4*w);
      wdata = $urandom;
      modelAccess(1'b1, 3'd2, addr, wdata, expRd, expEr);
      applyStimulus(1'b1, 3'd2, addr, wdata, lat, busyN, rd, er);
      checkOutput($sformatf("fill%0d err", w), 32'(er), 32'(expEr));
    end
    for (int i = 0; i < 60; i++) begin
      wr    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = (32'h200 + 32'($urandom_range(0, 60))) | (32'($urandom_range(0, 7)) << 17);
      wdata = $urandom;
      modelAccess(wr, f3, addr, wdata, expRd, expEr);
      applyStimulus(wr, f3, addr, wdata, lat, busyN, rd, er);
      checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'd2);
      checkOutput($sformatf("rand%0d rdata", i), rd, expRd);
      checkOutput($sformatf("rand%0d err", i), 32'(er), 32'(expEr));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
